// File: rtl/dual_mode_stack.sv
// Parametrised LIFO/FIFO buffer with run-time mode, simultaneous push/pop and occupancy count.
// Optional sticky overflow/underflow flags are built when DMS_ERR_FLAGS_EN is defined.
module dual_mode_stack #(
  parameter int W = 8,
  parameter int D = 8,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          clr_i,
  input  logic          mode_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_in_i,
  output logic [W-1:0]  data_out_o,
  output logic          out_valid_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          mode_q_o
`ifdef DMS_ERR_FLAGS_EN
  ,
  output logic          overflow_o,
  output logic          underflow_o
`endif
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [W-1:0]  dataOut_q, dataOut_d;
  logic          outValid_q, outValid_d;
  logic [CW-1:0] count_q, count_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic          isEmpty, isFull, popAcc, pushAcc;
  logic [PW-1:0] topIdx, rdAddr, wrAddr;
`ifdef DMS_ERR_FLAGS_EN
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
`endif

  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop frees a slot in the same cycle, so a full buffer still accepts push+pop.
  always_comb begin
    isEmpty = (count_q == '0);
    isFull  = (count_q == CW'(D));
    popAcc  = pop_i && !isEmpty;
    pushAcc = push_i && (!isFull || popAcc);
    topIdx  = PW'(count_q - CW'(1));
    rdAddr  = mode_q ? rdPtr_q : topIdx;
    if (isEmpty)
      wrAddr = '0;
    else if (mode_q)
      wrAddr = wrPtr_q;
    else
      wrAddr = popAcc ? topIdx : PW'(count_q);
  end

  always_comb begin
    dataOut_d  = dataOut_q;
    outValid_d = outValid_q;
    count_d    = count_q;
    mode_d     = mode_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
`ifdef DMS_ERR_FLAGS_EN
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
`endif
    if (clr_i) begin
      outValid_d = 1'b0;
      count_d    = '0;
      mode_d     = mode_i;
      rdPtr_d    = '0;
      wrPtr_d    = '0;
`ifdef DMS_ERR_FLAGS_EN
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
`endif
    end else begin
      outValid_d = popAcc;
      if (popAcc)
        dataOut_d = mem[rdAddr];
      if (pushAcc && !popAcc)
        count_d = count_q + CW'(1);
      else if (popAcc && !pushAcc)
        count_d = count_q - CW'(1);
      // An empty buffer restarts its pointers at 0 so the first push lands in mem[0].
      if (isEmpty) begin
        mode_d  = mode_i;
        rdPtr_d = '0;
        wrPtr_d = pushAcc ? PW'(1) : '0;
      end else if (mode_q) begin
        if (pushAcc)
          wrPtr_d = incPtr(wrPtr_q);
        if (popAcc)
          rdPtr_d = incPtr(rdPtr_q);
      end
`ifdef DMS_ERR_FLAGS_EN
      overflow_d  = overflow_q | (push_i && !pushAcc);
      underflow_d = underflow_q | (pop_i && !popAcc);
`endif
    end
  end

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      dataOut_q  <= '0;
      outValid_q <= 1'b0;
      count_q    <= '0;
      mode_q     <= 1'b0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
`ifdef DMS_ERR_FLAGS_EN
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`endif
    end else begin
      dataOut_q  <= dataOut_d;
      outValid_q <= outValid_d;
      count_q    <= count_d;
      mode_q     <= mode_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
`ifdef DMS_ERR_FLAGS_EN
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`endif
    end
  end

  // Storage has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rstN && !clr_i && pushAcc)
      mem[wrAddr] <= data_in_i;
  end

  assign data_out_o  = dataOut_q;
  assign out_valid_o = outValid_q;
  assign count_o     = count_q;
  assign full_o      = isFull;
  assign empty_o     = isEmpty;
  assign mode_q_o    = mode_q;
`ifdef DMS_ERR_FLAGS_EN
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_dual_mode_stack.sv
// Scoreboard bench for dual_mode_stack (W=8, D=8): stimulus queues expected pops, a monitor checks strobes.
module tb_dual_mode_stack;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       clrI = 1'b0;
  logic       modeI = 1'b0;
  logic       pushI = 1'b0;
  logic       popI = 1'b0;
  logic [7:0] dataIn = '0;
  logic [7:0] dataOut;
  logic       outValid;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       modeQ;
`ifdef DMS_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] expQ [$];

  dual_mode_stack #(.W(8), .D(8)) dut (
    .clk(clk),
    .rstN(rstN),
    .clr_i(clrI),
    .mode_i(modeI),
    .push_i(pushI),
    .pop_i(popI),
    .data_in_i(dataIn),
    .data_out_o(dataOut),
    .out_valid_o(outValid),
    .count_o(count),
    .full_o(full),
    .empty_o(empty),
    .mode_q_o(modeQ)
`ifdef DMS_ERR_FLAGS_EN
    ,
    .overflow_o(overflow),
    .underflow_o(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one request across a single rising edge, then return to idle.
  task automatic applyStimulus(input logic c, input logic pu, input logic po, input logic [7:0] d);
    clrI = c;
    pushI = pu;
    popI = po;
    dataIn = d;
    @(posedge clk);
    #1;
    clrI = 1'b0;
    pushI = 1'b0;
    popI = 1'b0;
  endtask

  task automatic pushVal(input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic popExpect(input logic [7:0] e);
    expQ.push_back(e);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic pushPopExpect(input logic [7:0] d, input logic [7:0] e);
    expQ.push_back(e);
    applyStimulus(1'b0, 1'b1, 1'b1, d);
  endtask

  always @(negedge clk) begin
    if (outValid) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedStrobe: got out_valid=1 data 0x%0h, expected no strobe", dataOut);
      end else begin
        logic [7:0] e;
        e = expQ.pop_front();
        checkOutput("dataOut", 32'(dataOut), 32'(e));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstDataOut", 32'(dataOut), 32'h0);
    checkOutput("rstValid", 32'(outValid), 32'h0);
    checkOutput("rstCount", 32'(count), 32'h0);
    checkOutput("rstFull", 32'(full), 32'h0);
    checkOutput("rstEmpty", 32'(empty), 32'h1);
    checkOutput("rstMode", 32'(modeQ), 32'h0);
    rstN = 1'b0;
    @(posedge clk);
    #1;

    // LIFO ordering
    modeI = 1'b0;
    pushVal(8'd1);
    pushVal(8'd2);
    pushVal(8'd3);
    checkOutput("lifoCount3", 32'(count), 32'd3);
    popExpect(8'd3);
    popExpect(8'd2);
    popExpect(8'd1);
    checkOutput("lifoCount0", 32'(count), 32'd0);
    checkOutput("lifoEmpty", 32'(empty), 32'h1);

    // FIFO fill, overflow, drain
    modeI = 1'b1;
    for (int i = 0; i < 8; i++) pushVal(8'h10 + 8'(i));
    checkOutput("fifoFull", 32'(full), 32'h1);
    checkOutput("fifoCount8", 32'(count), 32'd8);
    checkOutput("fifoMode", 32'(modeQ), 32'h1);
    pushVal(8'h99);
    checkOutput("ovfCount", 32'(count), 32'd8);
`ifdef DMS_ERR_FLAGS_EN
    checkOutput("overflowSet", 32'(overflow), 32'h1);
`endif
    for (int i = 0; i < 8; i++) popExpect(8'h10 + 8'(i));

    // FIFO pointer wrap
    for (int i = 0; i < 5; i++) pushVal(8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) popExpect(8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) pushVal(8'hB0 + 8'(i));
    checkOutput("wrapCount7", 32'(count), 32'd7);
    popExpect(8'hA3);
    popExpect(8'hA4);
    for (int i = 0; i < 5; i++) popExpect(8'hB0 + 8'(i));

    // FIFO full with simultaneous push and pop
    for (int i = 0; i < 8; i++) pushVal(8'h20 + 8'(i));
    pushPopExpect(8'h28, 8'h20);
    checkOutput("fullPpCount", 32'(count), 32'd8);
    checkOutput("fullPpFull", 32'(full), 32'h1);
    for (int i = 1; i < 9; i++) popExpect(8'h20 + 8'(i));

    // LIFO replace-top
    modeI = 1'b0;
    pushVal(8'd5);
    pushVal(8'd6);
    checkOutput("lifoModeBack", 32'(modeQ), 32'h0);
    pushPopExpect(8'd9, 8'd6);
    checkOutput("replaceCount", 32'(count), 32'd2);
    popExpect(8'd9);
    popExpect(8'd5);

    // Underflow on empty
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
`ifdef DMS_ERR_FLAGS_EN
    checkOutput("underflowSet", 32'(underflow), 32'h1);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd4);
    checkOutput("emptyPpCount", 32'(count), 32'd1);
    popExpect(8'd4);

    // Mode change only takes effect once drained
    pushVal(8'd7);
    pushVal(8'd8);
    modeI = 1'b1;
    pushVal(8'd9);
    checkOutput("modeHeld", 32'(modeQ), 32'h0);
    popExpect(8'd9);
    popExpect(8'd8);
    popExpect(8'd7);
    checkOutput("modeHeldDrain", 32'(modeQ), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("modeSwitched", 32'(modeQ), 32'h1);

    // Synchronous clear mid-stream, with a push ignored
    pushVal(8'h31);
    pushVal(8'h32);
    popExpect(8'h31);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
    checkOutput("clrCount", 32'(count), 32'd0);
    checkOutput("clrEmpty", 32'(empty), 32'h1);
    checkOutput("clrValid", 32'(outValid), 32'h0);
    checkOutput("clrDataHeld", 32'(dataOut), 32'h31);
`ifdef DMS_ERR_FLAGS_EN
    checkOutput("clrOverflow", 32'(overflow), 32'h0);
    checkOutput("clrUnderflow", 32'(underflow), 32'h0);
`endif

    // Asynchronous reset between edges
    for (int i = 0; i < 4; i++) pushVal(8'h40 + 8'(i));
    checkOutput("preRstCount", 32'(count), 32'd4);
    #2;
    rstN = 1'b1;
    #1;
    checkOutput("asyncDataOut", 32'(dataOut), 32'h0);
    checkOutput("asyncCount", 32'(count), 32'd0);
    checkOutput("asyncEmpty", 32'(empty), 32'h1);
    checkOutput("asyncFull", 32'(full), 32'h0);
    checkOutput("asyncMode", 32'(modeQ), 32'h0);
    checkOutput("asyncValid", 32'(outValid), 32'h0);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
